// File: rtl/sonic_v1_15_jtag_st_pkg.sv
// rtl/sonic_v1_15_jtag_st_pkg.sv - framing symbols, escape test and symbol FSM states for the JTAG byte stream
package sonic_v1_15_jtag_st_pkg;

  localparam logic [7:0] SOP_CHAR  = 8'h7A;
  localparam logic [7:0] EOP_CHAR  = 8'h7B;
  localparam logic [7:0] CHAN_CHAR = 8'h7C;
  localparam logic [7:0] ESC_CHAR  = 8'h7D;
  localparam logic [7:0] ESC_XOR   = 8'h20;

  // Encodings follow emission order so "next symbol" is simply +1.
  typedef enum logic [2:0] {
    CHAN_MARK = 3'd0,
    CHAN_ESC  = 3'd1,
    CHAN_VAL  = 3'd2,
    SOP_MARK  = 3'd3,
    EOP_MARK  = 3'd4,
    DATA_ESC  = 3'd5,
    DATA_VAL  = 3'd6
  } st_state_t;

  function automatic logic is_special(input logic [7:0] b);
    return (b >= SOP_CHAR) && (b <= ESC_CHAR);
  endfunction

endpackage

// File: rtl/sonic_v1_15_jtag_master_packets_to_bytes.sv
// rtl/sonic_v1_15_jtag_master_packets_to_bytes.sv - serialises channelised packets into an escaped, framed byte stream
module sonic_v1_15_jtag_master_packets_to_bytes #(
  parameter int CHANNEL_WIDTH  = 8,
  parameter int ENCODE_CHANNEL = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic [CHANNEL_WIDTH-1:0] in_channel,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data
);
  import sonic_v1_15_jtag_st_pkg::*;

  st_state_t                state;
  st_state_t                eff;
  logic [CHANNEL_WIDTH-1:0] last_channel;
  logic                     chan_valid;
  logic [7:0]               chan_byte;
  logic                     chan_need;
  logic [6:0]               app;
  logic                     found;
  logic                     fire;

  always_comb begin
    chan_byte                    = '0;
    chan_byte[CHANNEL_WIDTH-1:0] = in_channel;
  end

  assign chan_need = (ENCODE_CHANNEL != 0) && in_startofpacket &&
                     (!chan_valid || (in_channel != last_channel));

  always_comb begin
    app           = '0;
    app[CHAN_MARK] = chan_need;
    app[CHAN_ESC]  = chan_need && is_special(chan_byte);
    app[CHAN_VAL]  = chan_need;
    app[SOP_MARK]  = in_startofpacket;
    app[EOP_MARK]  = in_endofpacket;
    app[DATA_ESC]  = is_special(in_data);
    app[DATA_VAL]  = 1'b1;
  end

  // The register may point at a symbol this beat does not need; skip forward.
  always_comb begin
    eff   = DATA_VAL;
    found = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (!found && (3'(i) >= state) && app[i]) begin
        eff   = st_state_t'(3'(i));
        found = 1'b1;
      end
    end
  end

  assign out_valid = in_valid & reset_n;
  assign fire      = out_valid & out_ready;
  assign in_ready  = fire & (eff == DATA_VAL);

  always_comb begin
    out_data = 8'h00;
    if (reset_n) begin
      case (eff)
        CHAN_MARK: out_data = CHAN_CHAR;
        CHAN_ESC:  out_data = ESC_CHAR;
        CHAN_VAL:  out_data = is_special(chan_byte) ? (chan_byte ^ ESC_XOR) : chan_byte;
        SOP_MARK:  out_data = SOP_CHAR;
        EOP_MARK:  out_data = EOP_CHAR;
        DATA_ESC:  out_data = ESC_CHAR;
        DATA_VAL:  out_data = is_special(in_data) ? (in_data ^ ESC_XOR) : in_data;
        default:   out_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= CHAN_MARK;
      last_channel <= '0;
      chan_valid   <= 1'b0;
    end else if (fire) begin
      if (eff == DATA_VAL) begin
        state <= CHAN_MARK;
        if (chan_need) begin
          last_channel <= in_channel;
          chan_valid   <= 1'b1;
        end
      end else begin
        state <= st_state_t'(eff + 3'd1);
      end
    end
  end

endmodule

// File: tb/tb_sonic_v1_15_jtag_master_packets_to_bytes.sv
// tb/tb_sonic_v1_15_jtag_master_packets_to_bytes.sv - directed checks of the packet-to-byte framer
module tb_sonic_v1_15_jtag_master_packets_to_bytes;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid, n_in_valid;
  logic [7:0] in_data;
  logic       sop, eop;
  logic [7:0] in_channel;
  logic       out_ready;
  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic       n_in_ready, n_out_valid;
  logic [7:0] n_out_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sonic_v1_15_jtag_master_packets_to_bytes #(.CHANNEL_WIDTH(8), .ENCODE_CHANNEL(1)) dut (
    .clk(clk), .reset_n(reset_n), .in_ready(in_ready), .in_valid(in_valid),
    .in_data(in_data), .in_startofpacket(sop), .in_endofpacket(eop),
    .in_channel(in_channel), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data)
  );

  sonic_v1_15_jtag_master_packets_to_bytes #(.CHANNEL_WIDTH(8), .ENCODE_CHANNEL(0)) dut_nc (
    .clk(clk), .reset_n(reset_n), .in_ready(n_in_ready), .in_valid(n_in_valid),
    .in_data(in_data), .in_startofpacket(sop), .in_endofpacket(eop),
    .in_channel(in_channel), .out_ready(out_ready), .out_valid(n_out_valid),
    .out_data(n_out_data)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one beat with out_ready held high; exp holds byte k at [8k +: 8].
  task automatic beat(input bit nc, input logic [7:0] d, input logic s, input logic e,
                      input logic [7:0] ch, input int n, input logic [55:0] exp);
    @(negedge clk);
    in_data = d; sop = s; eop = e; in_channel = ch; out_ready = 1'b1;
    if (nc) n_in_valid = 1'b1; else in_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      #1;
      if (nc) begin
        chk("nc_valid", {7'd0, n_out_valid}, 8'd1);
        chk("nc_data", n_out_data, exp[8*k +: 8]);
        chk("nc_ready", {7'd0, n_in_ready}, {7'd0, k == n - 1});
      end else begin
        chk("valid", {7'd0, out_valid}, 8'd1);
        chk("data", out_data, exp[8*k +: 8]);
        chk("in_ready", {7'd0, in_ready}, {7'd0, k == n - 1});
      end
      @(negedge clk);
    end
    in_valid = 1'b0; n_in_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b1; n_in_valid = 1'b0; out_ready = 1'b1;
    in_data = 8'h41; sop = 1'b1; eop = 1'b1; in_channel = 8'h00;
    #1;
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_in_ready", {7'd0, in_ready}, 8'd0);
    chk("rst_out_data", out_data, 8'h00);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1; in_valid = 1'b0;

    beat(0, 8'h41, 1, 1, 8'h00, 5, 56'h41_7B_7A_00_7C);
    beat(0, 8'h11, 1, 0, 8'h02, 4, 56'h11_7A_02_7C);
    beat(0, 8'h22, 0, 0, 8'h02, 1, 56'h22);
    beat(0, 8'h33, 0, 1, 8'h02, 2, 56'h33_7B);
    beat(0, 8'h44, 1, 1, 8'h02, 3, 56'h44_7B_7A);
    beat(0, 8'h7A, 1, 1, 8'h7D, 7, 56'h5A_7D_7B_7A_5D_7D_7C);

    // Backpressure across an escaped 0x7B data byte: ready pattern 1,0,0,1.
    @(negedge clk);
    in_data = 8'h7B; sop = 1'b0; eop = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1; chk("bp0_data", out_data, 8'h7D); chk("bp0_rdy", {7'd0, in_ready}, 8'd0);
    @(negedge clk); out_ready = 1'b0;
    #1; chk("bp1_data", out_data, 8'h5B); chk("bp1_rdy", {7'd0, in_ready}, 8'd0);
    @(negedge clk);
    #1; chk("bp2_data", out_data, 8'h5B); chk("bp2_rdy", {7'd0, in_ready}, 8'd0);
    @(negedge clk); out_ready = 1'b1;
    #1; chk("bp3_data", out_data, 8'h5B); chk("bp3_rdy", {7'd0, in_ready}, 8'd1);
    @(negedge clk); in_valid = 1'b0;

    // Reset after two of five symbols; chan_valid must be cleared so ch 0 is re-announced.
    @(negedge clk);
    in_data = 8'h41; sop = 1'b1; eop = 1'b1; in_channel = 8'h00; in_valid = 1'b1;
    #1; chk("mid0_data", out_data, 8'h7C);
    @(negedge clk);
    #1; chk("mid1_data", out_data, 8'h00);
    @(negedge clk); reset_n = 1'b0;
    #1;
    chk("mrst_valid", {7'd0, out_valid}, 8'd0);
    chk("mrst_ready", {7'd0, in_ready}, 8'd0);
    chk("mrst_data", out_data, 8'h00);
    @(negedge clk); reset_n = 1'b1; in_valid = 1'b0;
    beat(0, 8'h41, 1, 1, 8'h00, 5, 56'h41_7B_7A_00_7C);

    // Channel on a non-SOP beat is ignored; same channel on next SOP gets no prefix.
    beat(0, 8'h7C, 0, 0, 8'h09, 2, 56'h5C_7D);
    beat(0, 8'h55, 1, 0, 8'h00, 2, 56'h55_7A);

    // Channel encoding disabled: never a CHAN_CHAR even when the channel changes.
    beat(1, 8'h7C, 1, 1, 8'h01, 4, 56'h5C_7D_7B_7A);
    beat(1, 8'h10, 1, 1, 8'h03, 3, 56'h10_7B_7A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sonic_v1_15_jtag_master_packets_to_bytes.md
Name: sonic_v1_15_jtag_master_packets_to_bytes

Overview:
- Downstream neighbour of the JTAG-master packet-to-byte channel adapter.
- Consumes channelised Avalon-ST packets: 8-bit data, SOP, EOP and an 8-bit channel.
- Serialises them into a flat byte stream with in-band framing and escape characters, ready for the JTAG byte transport.
- Purely flow-controlled expansion: one input beat becomes 1 to 7 output bytes, with no payload buffering beyond the beat being presented.

Parameters:
- CHANNEL_WIDTH, 8, width of in_channel; 1 to 8.
- ENCODE_CHANNEL, 1, 1 = emit channel prefixes; 0 = never emit channel symbols (channel ignored).

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous assert, active-low reset.
- in_ready  out  1  input beat consumed this cycle.
- in_valid  in  1  input beat present.
- in_data  in  8  payload byte.
- in_startofpacket  in  1  first beat of packet.
- in_endofpacket  in  1  last beat of packet.
- in_channel  in  CHANNEL_WIDTH  packet channel; sampled on SOP beats only.
- out_ready  in  1  downstream accepts byte.
- out_valid  out  1  byte available.
- out_data  out  8  framed byte stream.

Behaviour:
- Reserved symbols:
  - SOP_CHAR 0x7A, EOP_CHAR 0x7B, CHAN_CHAR 0x7C, ESC_CHAR 0x7D.
  - A byte is "special" iff it lies in 0x7A..0x7D.
  - A special byte b is sent as ESC_CHAR then b XOR 0x20.
- Per input beat, symbols are emitted in this fixed order, skipping inapplicable ones:
  1. CHAN_CHAR, if ENCODE_CHANNEL, SOP, and (in_channel != last_channel or chan_valid==0).
  2. Channel byte (zero-extended to 8 bits, escaped if special), under the same condition.
  3. SOP_CHAR, if SOP.
  4. EOP_CHAR, if EOP.
  5. Data byte, escaped if special.
- FSM states, in emission order: CHAN_MARK, CHAN_ESC, CHAN_VAL, SOP_MARK, EOP_MARK, DATA_ESC, DATA_VAL.
  - The register holds the current symbol.
  - It advances only on out_valid & out_ready, to the next applicable state (combinational skip).
  - From reset and after each beat completes, the effective state is the first applicable symbol of the beat presented.
- Outputs:
  - out_valid = in_valid (combinational).
  - out_data = the symbol selected by the current state and the held input.
  - No internal payload register: Avalon rule applies, and in_data/in_channel/SOP/EOP are held stable by upstream while in_ready is 0.
- in_ready = out_ready & in_valid & (state resolves to DATA_VAL).
  - Input is consumed in the same cycle the final data byte is accepted.
  - Zero added latency for non-special, non-framed bytes: 1 byte per cycle throughput.
- On SOP beat completion (when the channel was emitted): last_channel <= in_channel and chan_valid <= 1.
- in_channel is ignored on non-SOP beats; a channel change mid-packet has no effect.
- SOP and EOP on the same beat: both markers are sent (SOP_MARK then EOP_MARK).
- EOP always precedes the final data byte, never follows it.
- out_ready low: state holds and out_data is stable. in_valid deasserted mid-beat is a protocol violation; the FSM holds state and out_valid follows in_valid.
- Reset (asynchronous, any time including mid-beat):
  - state <= CHAN_MARK-start, last_channel <= 0, chan_valid <= 0.
  - in_ready=0 and out_valid=0 while reset_n=0.
  - A partially emitted beat is abandoned, not resumed.
- Worst-case expansion: 7 bytes per beat (special channel byte + SOP + EOP + special data).

Decomposition:
- Shared package sonic_v1_15_jtag_st_pkg holds:
  - SOP_CHAR, EOP_CHAR, CHAN_CHAR, ESC_CHAR, ESC_XOR (0x20);
  - is_special function;
  - state enum.
- The same package is to be reused by the bytes-to-packets decoder.
- No sub-module needed; escape logic is a package function.

Test Plan:
- Single 1-byte packet, ch 0, data 0x41, SOP+EOP, out_ready=1 -> bytes 7C 00 7A 7B 41; in_ready high only on the 5th cycle.
- 3-beat packet on ch 2 (11 22 33), then second packet on ch 2 (44, SOP+EOP) -> 7C 02 7A 11 22 7B 33 then 7A 7B 44; no channel prefix repeated.
- Special data: packet ch 0x7D, data 0x7A -> 7C 7D 5D 7A 7B 7D 5A.
- Backpressure: out_ready toggling 1,0,0,1 over the 0x7B-escape sequence -> out_data stable while stalled; byte sequence identical; in_ready only on the final accepted byte.
- Reset asserted after 2 of 5 symbols emitted; beat re-presented after release -> full sequence restarts from CHAN_CHAR (chan_valid cleared), outputs 0 during reset.
- ENCODE_CHANNEL=0 build: ch changes 1->3 across packets -> no 7C symbols ever emitted.
